pacman_anim: RTL and testbench

Pac-Man sprite animation sequencer; consumes the square-wave `open_close` level from the mouth-rate counter and turns each of its edges into one animation step. Tracks mouth frame (closed/half/open ping-pong), heading and a death sequence, and emits a registered sprite-ROM address for the row the draw logic requests. Sits between the rate counter / game-state logic and the Pac-Man sprite ROM in the colour mapper path.

---
 rtl/pacman_anim.sv | 117 +++++++++++
 tb/tb_pacman_anim.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_anim.sv
// Pac-Man sprite animation sequencer.
// Turns each edge of the mouth-rate square wave into one animation step,
// tracks the mouth ping-pong frame, heading and the death sequence, and
// produces a registered sprite-ROM address for the requested row.
module pacman_anim #(
   parameter int  DEATH_FRAMES = 8,
   parameter int  ROWS         = 16,
   localparam int RW           = $clog2(ROWS),
   localparam int AW           = $clog2((12 + DEATH_FRAMES) * ROWS)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          open_close,
   input  logic          moving,
   input  logic [1:0]    dir,
   input  logic          die,
   input  logic          respawn,
   input  logic [RW-1:0] row,
   output logic [AW-1:0] rom_addr,
   output logic [1:0]    mouth_frame,
   output logic          death_active,
   output logic          death_done
);

   // Frame index occupies the address bits above the row field; ROWS is a
   // power of two so the index can simply be concatenated with the row.
   localparam int IW = AW - RW;
   localparam int DW = 4;
   localparam logic [DW-1:0] LAST_DFRAME = DW'(DEATH_FRAMES - 1);

   typedef enum logic [1:0] {
      ALIVE,
      DYING,
      DEAD
   } state_t;

   state_t        state;
   logic          prev_oc;
   logic          step;
   logic          sweep_up;
   logic [DW-1:0] dframe;
   logic [IW-1:0] frame_index;

   assign step = open_close ^ prev_oc;

   // Select which sprite frame the current state maps to.
   always_comb begin
      frame_index = '0;
      if (state == ALIVE) begin
         frame_index = IW'(dir) * IW'(3) + IW'(mouth_frame);
      end else begin
         frame_index = IW'(12) + IW'(dframe);
      end
   end

   // Animation state machine, edge detector and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= ALIVE;
         prev_oc      <= open_close;
         sweep_up     <= 1'b1;
         dframe       <= '0;
         mouth_frame  <= 2'd0;
         death_active <= 1'b0;
         death_done   <= 1'b0;
         rom_addr     <= '0;
      end else begin
         prev_oc    <= open_close;
         death_done <= 1'b0;
         rom_addr   <= {frame_index, row};
         unique case (state)
            ALIVE: begin
               if (die) begin
                  state        <= DYING;
                  dframe       <= '0;
                  death_active <= 1'b1;
               end else if (step && moving) begin
                  if (sweep_up) begin
                     mouth_frame <= mouth_frame + 2'd1;
                     if (mouth_frame == 2'd1) begin
                        sweep_up <= 1'b0;
                     end
                  end else begin
                     mouth_frame <= mouth_frame - 2'd1;
                     if (mouth_frame == 2'd1) begin
                        sweep_up <= 1'b1;
                     end
                  end
               end
            end
            DYING: begin
               if (step) begin
                  if (dframe == LAST_DFRAME) begin
                     state      <= DEAD;
                     death_done <= 1'b1;
                  end else begin
                     dframe <= dframe + 1'b1;
                  end
               end
            end
            DEAD: begin
               if (respawn) begin
                  state        <= ALIVE;
                  mouth_frame  <= 2'd0;
                  sweep_up     <= 1'b1;
                  dframe       <= '0;
                  death_active <= 1'b0;
               end
            end
            default: begin
               state <= ALIVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pacman_anim.sv
// Self-checking bench for pacman_anim: a behavioural model pushes the
// expected outputs for every driven cycle into a scoreboard queue, which is
// popped and compared one clock edge later.
module tb_pacman_anim;

   localparam int DEATH_FRAMES = 8;
   localparam int ROWS         = 16;
   localparam int RW           = $clog2(ROWS);
   localparam int AW           = $clog2((12 + DEATH_FRAMES) * ROWS);

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          open_close = 1'b0;
   logic          moving = 1'b0;
   logic [1:0]    dir = 2'd0;
   logic          die = 1'b0;
   logic          respawn = 1'b0;
   logic [RW-1:0] row = '0;
   logic [AW-1:0] rom_addr;
   logic [1:0]    mouth_frame;
   logic          death_active;
   logic          death_done;

   typedef struct {
      int addr;
      int mouth;
      int active;
      int done;
   } expect_t;

   expect_t scoreboard[$];

   int check_count = 0;
   int fail_count  = 0;

   // Reference model state (0 alive, 1 dying, 2 dead).
   int m_state  = 0;
   int m_mouth  = 0;
   int m_up     = 1;
   int m_dframe = 0;
   int m_prev   = 0;

   pacman_anim #(
      .DEATH_FRAMES(DEATH_FRAMES),
      .ROWS(ROWS)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .open_close(open_close),
      .moving(moving),
      .dir(dir),
      .die(die),
      .respawn(respawn),
      .row(row),
      .rom_addr(rom_addr),
      .mouth_frame(mouth_frame),
      .death_active(death_active),
      .death_done(death_done)
   );

   // Free-running 100 MHz clock.
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep(output expect_t e);
      int step;
      e.done = 0;
      if (Reset) begin
         m_prev   = int'(open_close);
         m_state  = 0;
         m_mouth  = 0;
         m_up     = 1;
         m_dframe = 0;
         e.addr   = 0;
      end else begin
         step   = int'(open_close) ^ m_prev;
         m_prev = int'(open_close);
         if (m_state == 0) e.addr = (int'(dir) * 3 + m_mouth) * ROWS + int'(row);
         else              e.addr = (12 + m_dframe) * ROWS + int'(row);
         case (m_state)
            0: begin
               if (die) begin
                  m_state  = 1;
                  m_dframe = 0;
               end else if (step == 1 && moving) begin
                  if (m_up == 1) begin
                     m_mouth++;
                     if (m_mouth == 2) m_up = 0;
                  end else begin
                     m_mouth--;
                     if (m_mouth == 0) m_up = 1;
                  end
               end
            end
            1: begin
               if (step == 1) begin
                  if (m_dframe == DEATH_FRAMES - 1) begin
                     m_state = 2;
                     e.done  = 1;
                  end else begin
                     m_dframe++;
                  end
               end
            end
            default: begin
               if (respawn) begin
                  m_state  = 0;
                  m_mouth  = 0;
                  m_up     = 1;
                  m_dframe = 0;
               end
            end
         endcase
      end
      e.mouth  = m_mouth;
      e.active = (m_state != 0) ? 1 : 0;
   endtask

   // Push the expectation for the current inputs, clock once, then compare.
   task automatic applyStimulus();
      expect_t e;
      expect_t got;
      modelStep(e);
      scoreboard.push_back(e);
      @(posedge Clk);
      #1;
      got = scoreboard.pop_front();
      checkOutput("sb_addr", int'(rom_addr), got.addr);
      checkOutput("sb_mouth", int'(mouth_frame), got.mouth);
      checkOutput("sb_active", int'(death_active), got.active);
      checkOutput("sb_done", int'(death_done), got.done);
   endtask

   task automatic edgeStep();
      open_close = ~open_close;
      applyStimulus();
   endtask

   initial begin
      int seq[5];
      seq = '{1, 2, 1, 0, 1};

      // Reset with open_close high, then hold it for 20 cycles.
      Reset      = 1'b1;
      open_close = 1'b1;
      row        = 4'd3;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_addr", int'(rom_addr), 0);
      checkOutput("reset_active", int'(death_active), 0);
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus();
      checkOutput("idle_addr", int'(rom_addr), 3);
      checkOutput("idle_mouth", int'(mouth_frame), 0);

      // Moving left: mouth ping-pongs, address follows one cycle later.
      moving = 1'b1;
      dir    = 2'd1;
      row    = 4'd5;
      for (int i = 0; i < 5; i++) begin
         edgeStep();
         checkOutput("pingpong_mouth", int'(mouth_frame), seq[i]);
         applyStimulus();
         checkOutput("pingpong_addr", int'(rom_addr), (3 + seq[i]) * 16 + 5);
      end

      // Frozen mouth while not moving, heading change reaches the address.
      moving = 1'b0;
      for (int i = 0; i < 4; i++) edgeStep();
      checkOutput("frozen_mouth", int'(mouth_frame), 1);
      dir = 2'd3;
      applyStimulus();
      checkOutput("dir_down_addr", int'(rom_addr), 165);

      // Back-to-back edges: 1 -> 2 -> 1 -> 0 -> 1 -> 2 without gaps.
      moving = 1'b1;
      for (int i = 0; i < 5; i++) edgeStep();
      checkOutput("b2b_mouth", int'(mouth_frame), 2);

      // Death request coincident with an edge at frame 2.
      die = 1'b1;
      edgeStep();
      die = 1'b0;
      checkOutput("die_active", int'(death_active), 1);
      checkOutput("die_mouth_held", int'(mouth_frame), 2);
      applyStimulus();
      checkOutput("die_addr", int'(rom_addr), 192 + 5);
      for (int i = 0; i < 7; i++) edgeStep();
      applyStimulus();
      checkOutput("last_dframe_addr", int'(rom_addr), 304 + 5);
      edgeStep();
      checkOutput("death_done_pulse", int'(death_done), 1);
      applyStimulus();
      checkOutput("death_done_clear", int'(death_done), 0);
      checkOutput("dead_addr", int'(rom_addr), 304 + 5);
      die = 1'b1;
      applyStimulus();
      die = 1'b0;
      edgeStep();
      applyStimulus();
      checkOutput("dead_hold_addr", int'(rom_addr), 304 + 5);

      // Respawn from DEAD, then an ignored respawn while alive.
      respawn = 1'b1;
      applyStimulus();
      respawn = 1'b0;
      checkOutput("respawn_active", int'(death_active), 0);
      checkOutput("respawn_mouth", int'(mouth_frame), 0);
      applyStimulus();
      checkOutput("respawn_addr", int'(rom_addr), 3 * 48 + 5);
      respawn = 1'b1;
      applyStimulus();
      respawn = 1'b0;
      applyStimulus();

      // Reset part-way through the death sequence.
      die = 1'b1;
      applyStimulus();
      die = 1'b0;
      for (int i = 0; i < 3; i++) edgeStep();
      Reset = 1'b1;
      applyStimulus();
      Reset = 1'b0;
      checkOutput("mid_reset_active", int'(death_active), 0);
      checkOutput("mid_reset_addr", int'(rom_addr), 0);
      checkOutput("mid_reset_done", int'(death_done), 0);
      for (int i = 0; i < 10; i++) edgeStep();

      // Randomised traffic checked against the model.
      for (int i = 0; i < 300; i++) begin
         open_close = 1'($urandom_range(1, 0));
         moving     = 1'($urandom_range(3, 0) != 0);
         dir        = 2'($urandom_range(3, 0));
         row        = RW'($urandom_range(ROWS - 1, 0));
         die        = ($urandom_range(29, 0) == 0);
         respawn    = ($urandom_range(9, 0) == 0);
         Reset      = ($urandom_range(99, 0) == 0);
         applyStimulus();
      end
      Reset   = 1'b0;
      die     = 1'b0;
      respawn = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
